// File: rtl/bch_syndrome_sequencer.sv
// bch_syndrome_sequencer
//
// Controls a dsynN_method1 syndrome bank. Codeword chunks arrive over a
// valid/ready handshake. The chunk data itself goes straight to the bank, and
// this block only drives the bank's start / start_pipelined / ce inputs. After
// the last chunk of a codeword, the syndrome pipeline is flushed for
// PIPELINE_STAGES cycles. The concatenated final syndromes are then captured
// into a one-entry output register and offered to the error locator over a
// valid/ready handshake, together with an error-present flag.
//
// Parameters:
//   M                syndrome width (BCH_M(P))
//   NSYN             number of syndrome units in the bank
//   CYCLES           chunks per codeword, >= 2
//   PIPELINE_STAGES  pipeline depth of the syndrome units, 0..2
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   data_valid       upstream chunk valid
//   data_ready       chunk accepted when data_valid && data_ready
//   syn_start        bank start
//   syn_start_pipe   bank start_pipelined
//   syn_ce           bank clock enable
//   syn_in           concatenated synN outputs from the bank
//   out_valid        captured syndrome set available
//   out_ready        consumer takes the set when out_valid && out_ready
//   syn_out          captured syndromes
//   err_present      syn_out is nonzero
//
// Optional feature (compile-time macro BCH_SYN_ZERO_SKIP_EN):
//   An all-zero syndrome set is not presented downstream. Instead a one-cycle
//   pulse is emitted on clean, and clean_cnt (16-bit, saturating) counts the
//   clean codewords.
//     clean          one-cycle pulse per clean codeword
//     clean_cnt      saturating clean-codeword count
module bch_syndrome_sequencer #(
  parameter int unsigned M               = 4,
  parameter int unsigned NSYN            = 2,
  parameter int unsigned CYCLES          = 15,
  parameter int unsigned PIPELINE_STAGES = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                data_valid,
  output logic                data_ready,
  output logic                syn_start,
  output logic                syn_start_pipe,
  output logic                syn_ce,
  input  logic [NSYN*M-1:0]   syn_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NSYN*M-1:0]   syn_out,
  output logic                err_present
`ifdef BCH_SYN_ZERO_SKIP_EN
  ,
  output logic                clean,
  output logic [15:0]         clean_cnt
`endif
);

  localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CYCLES - 1);
  localparam logic [1:0] FLUSH_LAST =
    2'((PIPELINE_STAGES > 0) ? (PIPELINE_STAGES - 1) : 0);

  generate
    if (PIPELINE_STAGES > 2) begin : g_bad_stages
      $error("bch_syndrome_sequencer: PIPELINE_STAGES must be 0..2");
    end
    if (CYCLES < 2) begin : g_bad_cycles
      $error("bch_syndrome_sequencer: CYCLES must be >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    ACC   = 2'd0,
    FLUSH = 2'd1,
    CAP   = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [1:0]      flush_cnt;
  logic            acc;
  logic            load;
  logic            take;

  // The handshake and bank controls are combinational so that a chunk and its
  // ce/start land on the bank in the same cycle.
  always_comb begin
    data_ready = (state == ACC);
    acc        = data_valid && data_ready;
    syn_ce     = 1'b0;
    syn_start  = 1'b0;
    case (state)
      ACC: begin
        syn_ce    = acc;
        syn_start = acc && (cnt == '0);
      end
      FLUSH: syn_ce = 1'b1;
      default: ;
    endcase
    take = out_valid && out_ready;
    load = (state == CAP) && (!out_valid || out_ready)
`ifdef BCH_SYN_ZERO_SKIP_EN
           && (syn_in != '0)
`endif
           ;
  end

  // With two pipeline stages, the bank's second stage must see start one
  // ce-qualified cycle later than the first stage.
  generate
    if (PIPELINE_STAGES == 2) begin : g_start_d
      logic start_d;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          start_d <= 1'b0;
        end else if (syn_ce) begin
          start_d <= syn_start;
        end
      end
      assign syn_start_pipe = start_d;
    end else begin : g_start_direct
      assign syn_start_pipe = syn_start;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ACC;
      cnt         <= '0;
      flush_cnt   <= '0;
      out_valid   <= 1'b0;
      syn_out     <= '0;
      err_present <= 1'b0;
`ifdef BCH_SYN_ZERO_SKIP_EN
      clean       <= 1'b0;
      clean_cnt   <= '0;
`endif
    end else begin
`ifdef BCH_SYN_ZERO_SKIP_EN
      clean <= 1'b0;
`endif
      // A load takes priority over a take: simultaneous take+load keeps
      // out_valid high with the new set.
      if (load) begin
        out_valid <= 1'b1;
      end else if (take) begin
        out_valid <= 1'b0;
      end

      case (state)
        ACC: begin
          if (acc) begin
            if (cnt == CNT_LAST) begin
              cnt   <= '0;
              state <= (PIPELINE_STAGES > 0) ? FLUSH : CAP;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end

        FLUSH: begin
          if (flush_cnt == FLUSH_LAST) begin
            flush_cnt <= '0;
            state     <= CAP;
          end else begin
            flush_cnt <= flush_cnt + 2'd1;
          end
        end

        CAP: begin
          if (load) begin
            syn_out     <= syn_in;
            err_present <= |syn_in;
            state       <= ACC;
          end
`ifdef BCH_SYN_ZERO_SKIP_EN
          else if (syn_in == '0) begin
            // A clean codeword bypasses the output register entirely, so it
            // never waits on downstream backpressure.
            clean <= 1'b1;
            if (clean_cnt != '1) begin
              clean_cnt <= clean_cnt + 16'd1;
            end
            state <= ACC;
          end
`endif
        end

        default: state <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_bch_syndrome_sequencer.sv
// Testbench for bch_syndrome_sequencer (M=4, NSYN=2, CYCLES=15).
// u0 uses PIPELINE_STAGES=0 and u2 uses PIPELINE_STAGES=2. Each instance is
// driven by a small bit-serial GF(16) syndrome bank model (S1, S3, with
// primitive polynomial x^4+x+1). Bits are fed from position 14 down to 0.
// Hand-computed golden values:
//   error at pos 3 -> {S3,S1} = {a^9,a^3}  = 8'hA8
//   error at pos 0 -> {1,1}               = 8'h11
//   error at pos 5 -> {a^15,a^5}          = 8'h16
module tb_bch_syndrome_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic dv0, dr0, st0, stp0, ce0, ov0, or0, err0, bit0;
  logic dv2, dr2, st2, stp2, ce2, ov2, or2, err2, bit2;
  logic [7:0] si0, so0, si2, so2;
`ifdef BCH_SYN_ZERO_SKIP_EN
  logic clean0, clean2;
  logic [15:0] ccnt0, ccnt2;
`endif

  int nchk  = 0;
  int npass = 0;

  bch_syndrome_sequencer #(.M(4), .NSYN(2), .CYCLES(15), .PIPELINE_STAGES(0)) u0 (
    .clk(clk), .rst_n(rst_n), .data_valid(dv0), .data_ready(dr0),
    .syn_start(st0), .syn_start_pipe(stp0), .syn_ce(ce0), .syn_in(si0),
    .out_valid(ov0), .out_ready(or0), .syn_out(so0), .err_present(err0)
`ifdef BCH_SYN_ZERO_SKIP_EN
    , .clean(clean0), .clean_cnt(ccnt0)
`endif
  );

  bch_syndrome_sequencer #(.M(4), .NSYN(2), .CYCLES(15), .PIPELINE_STAGES(2)) u2 (
    .clk(clk), .rst_n(rst_n), .data_valid(dv2), .data_ready(dr2),
    .syn_start(st2), .syn_start_pipe(stp2), .syn_ce(ce2), .syn_in(si2),
    .out_valid(ov2), .out_ready(or2), .syn_out(so2), .err_present(err2)
`ifdef BCH_SYN_ZERO_SKIP_EN
    , .clean(clean2), .clean_cnt(ccnt2)
`endif
  );

  // ---------------- syndrome bank models ----------------
  function automatic logic [3:0] mula(input logic [3:0] x);
    return {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
  endfunction

  logic [3:0] b0s1 = '0, b0s3 = '0, b2s1 = '0, b2s3 = '0;
  logic [7:0] p1 = '0, p2 = '0;

  always @(posedge clk) begin
    if (ce0) begin
      b0s1 <= st0 ? {3'b000, bit0} : (mula(b0s1) ^ {3'b000, bit0});
      b0s3 <= st0 ? {3'b000, bit0} : (mula(mula(mula(b0s3))) ^ {3'b000, bit0});
    end
    if (ce2) begin
      b2s1 <= st2 ? {3'b000, bit2} : (mula(b2s1) ^ {3'b000, bit2});
      b2s3 <= st2 ? {3'b000, bit2} : (mula(mula(mula(b2s3))) ^ {3'b000, bit2});
      p1   <= {b2s3, b2s1};
      p2   <= p1;
    end
  end
  assign si0 = {b0s3, b0s1};
  assign si2 = p2;

  // ---------------- stimulus ----------------
  // Entered and left at posedge+1. Streams n chunks (index 0..n-1, bit
  // position 14-i). Records start / start_pipe per accepted chunk, and ce
  // seen during gap cycles.
  task automatic stream(input int sel, input int errpos, input int n, input bit gaps,
                        output logic [14:0] starts, output logic [14:0] startps,
                        output int gap_ce, output bit timeout);
    int i;
    int budget;
    bit ph;
    logic v, rdy, s, sp, c;
    i = 0; budget = 200; ph = 1'b0;
    starts = '0; startps = '0; gap_ce = 0;
    while (i < n && budget > 0) begin
      v  = gaps ? ph : 1'b1;
      ph = ~ph;
      if (sel == 0) begin dv0 = v; bit0 = ((14 - i) == errpos); end
      else          begin dv2 = v; bit2 = ((14 - i) == errpos); end
      @(negedge clk);
      if (sel == 0) begin rdy = dr0; s = st0; sp = stp0; c = ce0; end
      else          begin rdy = dr2; s = st2; sp = stp2; c = ce2; end
      if (!v && c) gap_ce++;
      if (v && rdy) begin
        starts[i]  = s;
        startps[i] = sp;
        i++;
      end
      @(posedge clk); #1;
      budget--;
    end
    dv0 = 1'b0; dv2 = 1'b0; bit0 = 1'b0; bit2 = 1'b0;
    timeout = (i < n);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    nchk++; if (ov0 !== 1'b0)  $display("FAIL reset_out_valid: got %b want 0", ov0); else npass++;
    nchk++; if (so0 !== 8'h00) $display("FAIL reset_syn_out: got %h want 00", so0); else npass++;
    nchk++; if (err0 !== 1'b0) $display("FAIL reset_err_present: got %b want 0", err0); else npass++;
    nchk++; if (dr0 !== 1'b1)  $display("FAIL reset_data_ready: got %b want 1", dr0); else npass++;
    nchk++; if ({st0, stp0, ce0} !== 3'b000) $display("FAIL reset_bank_ctl: got %b want 000", {st0, stp0, ce0}); else npass++;
    nchk++; if ({ov2, stp2} !== 2'b00) $display("FAIL reset_u2: got %b want 00", {ov2, stp2}); else npass++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_zero_word();
    logic [14:0] sts, stps; int gce; bit to;
    or0 = 1'b1;
    stream(0, -1, 15, 1'b0, sts, stps, gce, to);
    nchk++; if (to !== 1'b0) $display("FAIL zero_timeout: got %b want 0", to); else npass++;
    nchk++; if (sts !== 15'h0001) $display("FAIL zero_start_pattern: got %h want 0001", sts); else npass++;
    @(negedge clk);  // t+1: CAP
    nchk++; if ({ov0, dr0, ce0} !== 3'b000) $display("FAIL zero_cap_cycle: got %b want 000", {ov0, dr0, ce0}); else npass++;
    @(negedge clk);  // t+2
`ifdef BCH_SYN_ZERO_SKIP_EN
    nchk++; if ({ov0, clean0} !== 2'b01) $display("FAIL zero_skip_pulse: got %b want 01", {ov0, clean0}); else npass++;
`else
    nchk++; if (ov0 !== 1'b1) $display("FAIL zero_out_valid: got %b want 1", ov0); else npass++;
    nchk++; if ({so0, err0} !== 9'h000) $display("FAIL zero_syn_out: got %h want 000", {so0, err0}); else npass++;
`endif
    nchk++; if (dr0 !== 1'b1) $display("FAIL zero_ready_again: got %b want 1", dr0); else npass++;
    @(negedge clk);  // t+3
    nchk++; if (ov0 !== 1'b0) $display("FAIL zero_valid_drop: got %b want 0", ov0); else npass++;
    @(posedge clk); #1;
  endtask

  task automatic test_single_error();
    logic [14:0] sts, stps; int gce; bit to;
    or0 = 1'b1;
    stream(0, 3, 15, 1'b0, sts, stps, gce, to);
    nchk++; if (to !== 1'b0) $display("FAIL err3_timeout: got %b want 0", to); else npass++;
    @(negedge clk);
    nchk++; if (ov0 !== 1'b0) $display("FAIL err3_latency_early: got %b want 0", ov0); else npass++;
    @(negedge clk);
    nchk++; if (ov0 !== 1'b1) $display("FAIL err3_out_valid: got %b want 1", ov0); else npass++;
    nchk++; if (so0 !== 8'hA8) $display("FAIL err3_syn_out: got %h want a8", so0); else npass++;
    nchk++; if (err0 !== 1'b1) $display("FAIL err3_err_present: got %b want 1", err0); else npass++;
    @(negedge clk);
    nchk++; if (ov0 !== 1'b0) $display("FAIL err3_single_pulse: got %b want 0", ov0); else npass++;
    @(posedge clk); #1;
  endtask

  task automatic test_pipeline();
    logic [14:0] sts, stps; int gce; bit to;
    or2 = 1'b1;
    stream(2, 3, 15, 1'b0, sts, stps, gce, to);
    nchk++; if (to !== 1'b0) $display("FAIL pipe_timeout: got %b want 0", to); else npass++;
    nchk++; if (sts !== 15'h0001) $display("FAIL pipe_start: got %h want 0001", sts); else npass++;
    nchk++; if (stps !== 15'h0002) $display("FAIL pipe_start_pipe: got %h want 0002", stps); else npass++;
    @(negedge clk);  // t+1 flush
    nchk++; if ({ce2, dr2, ov2} !== 3'b100) $display("FAIL pipe_flush1: got %b want 100", {ce2, dr2, ov2}); else npass++;
    @(negedge clk);  // t+2 flush
    nchk++; if ({ce2, dr2, ov2} !== 3'b100) $display("FAIL pipe_flush2: got %b want 100", {ce2, dr2, ov2}); else npass++;
    @(negedge clk);  // t+3 CAP
    nchk++; if ({ce2, dr2, ov2} !== 3'b000) $display("FAIL pipe_cap: got %b want 000", {ce2, dr2, ov2}); else npass++;
    @(negedge clk);  // t+4
    nchk++; if ({ov2, err2} !== 2'b11) $display("FAIL pipe_out_valid: got %b want 11", {ov2, err2}); else npass++;
    nchk++; if (so2 !== 8'hA8) $display("FAIL pipe_syn_out: got %h want a8", so2); else npass++;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [14:0] sts, stps; int gce; bit to;
    int stall_bad;
    or0 = 1'b0;
    stream(0, 3, 15, 1'b0, sts, stps, gce, to);
    @(negedge clk); @(negedge clk);
    nchk++; if ({ov0, so0} !== 9'h1A8) $display("FAIL bp_first: got %h want 1a8", {ov0, so0}); else npass++;
    @(posedge clk); #1;
    stream(0, 0, 15, 1'b0, sts, stps, gce, to);
    nchk++; if (to !== 1'b0) $display("FAIL bp_second_timeout: got %b want 0", to); else npass++;
    stall_bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if ({dr0, ov0, so0, err0} !== {1'b0, 1'b1, 8'hA8, 1'b1}) stall_bad++;
      @(posedge clk); #1;
    end
    nchk++; if (stall_bad !== 0) $display("FAIL bp_stall_stable: got %0d bad cycles want 0", stall_bad); else npass++;
    or0 = 1'b1;
    @(negedge clk);
    nchk++; if ({ov0, so0} !== 9'h1A8) $display("FAIL bp_release_first: got %h want 1a8", {ov0, so0}); else npass++;
    @(negedge clk);
    nchk++; if ({ov0, so0, err0} !== {1'b1, 8'h11, 1'b1}) $display("FAIL bp_second: got %h want 223", {ov0, so0, err0}); else npass++;
    nchk++; if (dr0 !== 1'b1) $display("FAIL bp_ready_after: got %b want 1", dr0); else npass++;
    @(negedge clk);
    nchk++; if (ov0 !== 1'b0) $display("FAIL bp_drain: got %b want 0", ov0); else npass++;
    @(posedge clk); #1;
  endtask

  task automatic test_gaps();
    logic [14:0] sts, stps; int gce; bit to;
    or0 = 1'b1;
    stream(0, 3, 15, 1'b1, sts, stps, gce, to);
    nchk++; if (to !== 1'b0) $display("FAIL gaps_timeout: got %b want 0", to); else npass++;
    nchk++; if (gce !== 0) $display("FAIL gaps_ce_low: got %0d want 0", gce); else npass++;
    nchk++; if (sts !== 15'h0001) $display("FAIL gaps_start: got %h want 0001", sts); else npass++;
    @(negedge clk); @(negedge clk);
    nchk++; if ({ov0, so0} !== 9'h1A8) $display("FAIL gaps_syn_out: got %h want 1a8", {ov0, so0}); else npass++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midword();
    logic [14:0] sts, stps; int gce; bit to;
    or0 = 1'b0;
    stream(0, 5, 15, 1'b0, sts, stps, gce, to);
    @(negedge clk); @(negedge clk);
    nchk++; if ({ov0, so0} !== 9'h116) $display("FAIL rst_pre_word: got %h want 116", {ov0, so0}); else npass++;
    @(posedge clk); #1;
    stream(0, -1, 7, 1'b0, sts, stps, gce, to);
    #2 rst_n = 1'b0;
    #1;
    nchk++; if ({ov0, so0, err0} !== 10'h000) $display("FAIL rst_async_clear: got %h want 000", {ov0, so0, err0}); else npass++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    or0 = 1'b1;
    stream(0, 3, 15, 1'b0, sts, stps, gce, to);
    nchk++; if (sts !== 15'h0001) $display("FAIL rst_rearm_start: got %h want 0001", sts); else npass++;
    @(negedge clk); @(negedge clk);
    nchk++; if ({ov0, so0, err0} !== {1'b1, 8'hA8, 1'b1}) $display("FAIL rst_next_word: got %h want 351", {ov0, so0, err0}); else npass++;
    @(posedge clk); #1;
  endtask

`ifdef BCH_SYN_ZERO_SKIP_EN
  task automatic test_zero_skip();
    logic [14:0] sts, stps; int gce; bit to;
    int ncl, nov, nerr;
    or0 = 1'b1;
    ncl = 0; nov = 0; nerr = 0;
    for (int w = 0; w < 4; w++) begin
      stream(0, (w == 3) ? 3 : -1, 15, 1'b0, sts, stps, gce, to);
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        if (clean0) ncl++;
        if (ov0) begin nov++; if (err0) nerr++; end
      end
      @(posedge clk); #1;
    end
    nchk++; if (ncl !== 3) $display("FAIL skip_clean_pulses: got %0d want 3", ncl); else npass++;
    nchk++; if (ccnt0 !== 16'd3) $display("FAIL skip_clean_cnt: got %0d want 3", ccnt0); else npass++;
    nchk++; if (nov !== 1) $display("FAIL skip_out_valid_count: got %0d want 1", nov); else npass++;
    nchk++; if (nerr !== 1) $display("FAIL skip_err_present: got %0d want 1", nerr); else npass++;
    nchk++; if (ccnt2 !== 16'd0) $display("FAIL skip_u2_clean_cnt: got %0d want 0", ccnt2); else npass++;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    dv0 = 1'b0; dv2 = 1'b0; bit0 = 1'b0; bit2 = 1'b0;
    or0 = 1'b1; or2 = 1'b1;
    test_reset();
    test_zero_word();
    test_single_error();
    test_pipeline();
    test_backpressure();
    test_gaps();
    test_reset_midword();
`ifdef BCH_SYN_ZERO_SKIP_EN
    test_zero_skip();
`endif
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
